i2c_arbiter: RTL
================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535: maximum cycles spent waiting in WAIT_DONE.
REQ-003 SHALL have parameter BUSY_CYC, default 16: maximum cycles spent waiting in WAIT_BUSY.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, NREQ bits: requester i has a command pending.
REQ-007 SHALL have port req_ready, output, NREQ bits: command accepted, one-hot, one-cycle pulse.
REQ-008 SHALL have port req_rw, input, NREQ bits: 1 = read, 0 = write.
REQ-009 SHALL have port req_speed, input, NREQ bits: 0 = 100 kbps, 1 = 400 kbps.
REQ-010 SHALL have port req_addr, input, NREQ*7 bits: packed 7-bit slave addresses.
REQ-011 SHALL have port req_wdata, input, NREQ*8 bits: packed write bytes.
REQ-012 SHALL have port rsp_done, output, NREQ bits: one-hot, one-cycle completion pulse.
REQ-013 SHALL have port rsp_err, output, 1 bit: timeout or NACK; valid only with rsp_done.
REQ-014 SHALL have port rsp_rdata, output, 8 bits: read byte; valid only with rsp_done.
REQ-015 SHALL have master-side outputs mst_start (1), mst_rw (1), mst_speed (1), mst_addr (7), mst_wdata (8), mst_abort (1).
REQ-016 SHALL have master-side inputs mst_ready (1: master idle), mst_rdata (8), mst_nack (1: sticky until next start).

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and RESP.
REQ-018 In IDLE, when any req_valid is high and mst_ready=1, SHALL pick a winner g round-robin, searching from last_grant+1 with wrap-around at NREQ-1 to 0.
REQ-019 In that same cycle, SHALL drive req_ready[g]=1 combinationally, latch g and g's rw/speed/addr/wdata, and go to ISSUE.
REQ-020 Once req_ready[g] has pulsed, the requester may change or drop its inputs; the arbiter SHALL use only the latched copies.
REQ-021 In IDLE with mst_ready=0, SHALL grant nothing and stay in IDLE.
REQ-022 In ISSUE, SHALL assert mst_start for exactly one cycle with the latched fields on the mst_* outputs, then go to WAIT_BUSY.
REQ-023 Grant-to-start latency SHALL be 1 cycle.
REQ-024 mst_rw/speed/addr/wdata SHALL hold their values from ISSUE until leaving RESP.
REQ-025 In WAIT_BUSY, when mst_ready=0, SHALL go to WAIT_DONE.
REQ-026 If BUSY_CYC cycles pass in WAIT_BUSY without mst_ready=0, SHALL set the error flag and go to RESP.
REQ-027 In WAIT_DONE, when mst_ready=1, SHALL capture mst_rdata and mst_nack and go to RESP.
REQ-028 If TIMEOUT_CYC cycles pass in WAIT_DONE, SHALL set the error flag, pulse mst_abort for one cycle, and go to RESP.
REQ-029 The wait counter SHALL be 16 bits, clear on every state entry, and saturate (never wrap).
REQ-030 In RESP, SHALL pulse rsp_done[g] for one cycle, drive rsp_err = timeout OR nack, and drive rsp_rdata (0x00 for writes or on error).
REQ-031 On leaving RESP, SHALL set last_grant to g and return to IDLE.
REQ-032 The earliest next grant SHALL be the cycle after RESP.
REQ-033 A requester that raises req_valid while its own transaction is in flight SHALL be queued, never served concurrently.
REQ-034 Withdrawing req_valid before req_ready SHALL be legal and SHALL cancel that request.

Reset
REQ-035 While rst=0, SHALL asynchronously force state to IDLE and last_grant to NREQ-1 (so requester 0 wins first).
REQ-036 While rst=0, SHALL force every output to 0 and clear the counter and latches.
REQ-037 A reset asserted mid-transaction SHALL issue no rsp_done and no mst_abort.
REQ-038 After reset releases, SHALL resume operation on the first rising clk edge.

Structure
REQ-039 State encoding, default TIMEOUT_CYC/BUSY_CYC and the speed code constants SHALL live in a shared package i2c_pkg, also used by the I2C master.
REQ-040 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, last grant; output: one-hot grant), purely combinational.

Verification
REQ-041 After reset, req_valid=4'b1111, mst_ready=1 -> grant order 0,1,2,3,0, with each req_ready one cycle before its mst_start.
REQ-042 Requester 2 write, addr 0x50, wdata 0xA5; master drops ready 3 cycles later and raises it after 200 cycles -> mst_addr=0x50, mst_wdata=0xA5, rsp_done[2], rsp_err=0.
REQ-043 Requester 1 read; master returns mst_rdata=0x3C, nack=0 -> rsp_rdata=0x3C, rsp_err=0.
REQ-044 TIMEOUT_CYC=100; master never re-raises ready -> mst_abort pulses at cycle 100 of WAIT_DONE, then rsp_err=1, rsp_rdata=0x00.
REQ-045 Master never drops ready after start -> error after 16 cycles, no mst_abort.
REQ-046 rst=0 during WAIT_DONE -> all outputs 0 at once, no rsp_done; the next grant goes to requester 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Purpose : shared I2C definitions for the arbiter and the I2C master.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: arbiter state encoding, default wait limits, bus speed codes.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } arb_state_t;

    localparam int I2C_TIMEOUT_CYC_DEF = 65535;
    localparam int I2C_BUSY_CYC_DEF    = 16;

    localparam logic I2C_SPEED_100K = 1'b0;
    localparam logic I2C_SPEED_400K = 1'b1;

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// Purpose : round-robin pick, searching upward from i_last+1 with wrap.
// Latency : purely combinational.
// Backpr. : none; o_grant is all-zero when i_req is all-zero.
// Ports   : i_req request vector, i_last previous winner index, o_grant one-hot.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant
);

    logic [IW-1:0] w_sel;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sel   = '0;
        // Offset NREQ lands back on i_last itself, so the last winner is
        // only chosen when it is the sole requester.
        for (int k = 1; k <= NREQ; k++) begin
            w_sel = IW'((int'(i_last) + k) % NREQ);
            if (!w_found && i_req[w_sel]) begin
                o_grant[w_sel] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Purpose : shares one I2C master among NREQ requesters, round-robin.
// Latency : req_ready is combinational in IDLE; mst_start follows 1 cycle later.
// Backpr. : no grant while the master is busy (mst_ready=0) or a transfer is open.
// Ports   : req_* requester side (packed addr/wdata), rsp_* one-hot completion,
//           mst_* master side; clk rising edge, rst asynchronous active-low.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = I2C_TIMEOUT_CYC_DEF,
    parameter int BUSY_CYC    = I2C_BUSY_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [NREQ-1:0]   req_speed,
    input  logic [NREQ*7-1:0] req_addr,
    input  logic [NREQ*8-1:0] req_wdata,
    output logic [NREQ-1:0]   rsp_done,
    output logic              rsp_err,
    output logic [7:0]        rsp_rdata,
    output logic              mst_start,
    output logic              mst_rw,
    output logic              mst_speed,
    output logic [6:0]        mst_addr,
    output logic [7:0]        mst_wdata,
    output logic              mst_abort,
    input  logic              mst_ready,
    input  logic [7:0]        mst_rdata,
    input  logic              mst_nack
);

    localparam int          IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] BUSY_LIM = 16'(BUSY_CYC - 1);
    localparam logic [15:0] TO_LIM   = 16'(TIMEOUT_CYC - 1);

    arb_state_t      r_state, w_next;
    logic [IW-1:0]   r_last, r_gnt, w_gnt_idx;
    logic [NREQ-1:0] w_pick;
    logic [15:0]     r_cnt;
    logic            r_rw, r_speed, r_nack, r_to;
    logic [6:0]      r_addr;
    logic [7:0]      r_wdata, r_rdata;
    logic            w_grant, w_busy_to, w_done_to, w_cap, w_err;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_grant (w_pick)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick[i]) w_gnt_idx = IW'(i);
        end
    end

    // rst gates the grant so req_ready stays low for the whole reset window.
    assign w_grant   = rst && (r_state == ST_IDLE) && mst_ready && (|req_valid);
    assign w_busy_to = (r_state == ST_WAIT_BUSY) && mst_ready && (r_cnt == BUSY_LIM);
    assign w_done_to = (r_state == ST_WAIT_DONE) && !mst_ready && (r_cnt == TO_LIM);
    assign w_cap     = (r_state == ST_WAIT_DONE) && mst_ready;
    assign w_err     = r_to | r_nack;

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        mst_start = 1'b0;
        mst_abort = 1'b0;
        rsp_done  = '0;
        rsp_err   = 1'b0;
        rsp_rdata = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    req_ready = w_pick;
                    w_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mst_start = 1'b1;
                w_next    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!mst_ready)    w_next = ST_WAIT_DONE;
                else if (w_busy_to) w_next = ST_RESP;
            end
            ST_WAIT_DONE: begin
                // A completion arriving on the timeout cycle wins over the abort.
                if (mst_ready) begin
                    w_next = ST_RESP;
                end else if (w_done_to) begin
                    mst_abort = 1'b1;
                    w_next    = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_done[r_gnt] = 1'b1;
                rsp_err         = w_err;
                rsp_rdata       = (r_rw && !w_err) ? r_rdata : 8'h00;
                w_next          = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_last  <= IW'(NREQ - 1);
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_speed <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_nack  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_next;
            // Counter restarts on every state change and sticks at all-ones.
            if (w_next != r_state)    r_cnt <= '0;
            else if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
            if (w_grant) begin
                r_gnt   <= w_gnt_idx;
                r_rw    <= req_rw[w_gnt_idx];
                r_speed <= req_speed[w_gnt_idx];
                r_addr  <= req_addr[int'(w_gnt_idx)*7 +: 7];
                r_wdata <= req_wdata[int'(w_gnt_idx)*8 +: 8];
                r_rdata <= '0;
                r_nack  <= 1'b0;
                r_to    <= 1'b0;
            end
            if (w_cap) begin
                r_rdata <= mst_rdata;
                r_nack  <= mst_nack;
            end
            if (w_busy_to || w_done_to) r_to <= 1'b1;
            if (r_state == ST_RESP)     r_last <= r_gnt;
        end
    end

    // Latched fields stay on the bus from ISSUE until the next grant.
    assign mst_rw    = r_rw;
    assign mst_speed = r_speed;
    assign mst_addr  = r_addr;
    assign mst_wdata = r_wdata;

endmodule
